mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Consumer end of the EX/MEM pipeline register: takes the MEM_* control/data bundle, performs the
//  data-memory access over a req/ack bus, stalls upstream while the access is pending, and loads the
//  MEM/WB pipeline register. Sits between EX_MEM and the write-back mux of the 19-bit pipelined CPU.
// PARAMETERS
//  DATA_W    19   datapath width (MEM_out, MEM_wdata, dmem data)
//  ADDR_W    10   dmem address width; dmem_addr = MEM_out[ADDR_W-1:0]
//  RD_W      3    destination register index width
//  TIMEOUT   15   max cycles waiting for dmem_ack before forced completion (>=1)
// PORTS
//  clk           in   1       system clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  MEM_regwrite  in   1       from EX_MEM: instruction writes a register
//  MEM_memtoreg  in   1       from EX_MEM: write-back selects memory data
//  MEM_memread   in   1       from EX_MEM: load
//  MEM_memwrite  in   1       from EX_MEM: store
//  MEM_out       in   DATA_W  from EX_MEM: ALU result / effective address
//  MEM_wdata     in   DATA_W  from EX_MEM: store data
//  MEM_rd        in   RD_W    from EX_MEM: destination register
//  dmem_req      out  1       access request, held until ack
//  dmem_we       out  1       1 = write, 0 = read; valid while dmem_req
//  dmem_addr     out  ADDR_W  access address; stable while dmem_req
//  dmem_wdata    out  DATA_W  store data; stable while dmem_req
//  dmem_ack      in   1       access complete; dmem_rdata valid same cycle for reads
//  dmem_rdata    in   DATA_W  read data
//  mem_stall     out  1       freeze PC, IF_ID, ID_EX, EX_MEM this cycle
//  bus_err       out  1       sticky: an access timed out; cleared only by rst
//  WB_regwrite   out  1       MEM/WB: register write enable
//  WB_memtoreg   out  1       MEM/WB: select WB_rdata
//  WB_out        out  DATA_W  MEM/WB: ALU result
//  WB_rdata      out  DATA_W  MEM/WB: loaded data
//  WB_rd         out  RD_W    MEM/WB: destination register
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0, all outputs 0 (dmem_req, mem_stall, bus_err, all WB_*).
//  - access = MEM_memread | MEM_memwrite. Both set -> treated as a store (dmem_we=1); regwrite/memtoreg still pass.
//  - FSM IDLE:
//      !access: MEM/WB loads MEM_* bundle at next edge (latency 1); WB_rdata <= 0; mem_stall=0.
//      access : mem_stall=1 (comb.); latch addr/we/wdata; -> BUSY; MEM/WB loads bubble (all controls 0).
//  - FSM BUSY: dmem_req=1. dmem_ack ignored in IDLE.
//      !dmem_ack & cnt<TIMEOUT-1: mem_stall=1, cnt++, MEM/WB loads bubble.
//      dmem_ack: mem_stall=0; MEM/WB loads bundle, WB_rdata <= dmem_rdata (read) or 0 (write); cnt<=0; -> IDLE.
//      no ack & cnt==TIMEOUT-1: treat as ack with rdata=0, set bus_err, -> IDLE.
//  - Minimum memory-op latency: 2 cycles (IDLE edge + BUSY cycle with ack). EX_MEM advances on the ack edge,
//    so the next instruction is evaluated in IDLE the following cycle; back-to-back accesses have no gap cycle.
//  - dmem_addr/we/wdata come from the latch, never directly from MEM_*; stable across the whole request.
//  - rst mid-access: request dropped immediately (async), no WB side effect; the pending op is lost.
//  - Counter width = clog2(TIMEOUT)+1; never wraps.
// STRUCTURE
//  - cpu19_pkg: DATA_W/RD_W constants, FSM state encoding (IDLE=0, BUSY=1), dmem request struct/macros.
//  - One sub-module: mem_wb_reg (async-reset MEM/WB register with load and bubble inputs).
//  - Top holds FSM, timeout counter, request latch and stall logic.
// TESTING
//  1 ALU op: regwrite=1, out=19'h1A5A5, rd=5, no access -> next edge WB_out=1A5A5, WB_rd=5, WB_regwrite=1, no req.
//  2 load: memread=1, memtoreg=1, out=19'h00123, ack 3 cycles later with rdata=19'h15A5A -> dmem_addr=10'h123,
//    we=0; mem_stall high 4 cycles; bubbles in WB; then WB_rdata=15A5A, WB_memtoreg=1.
//  3 store: memwrite=1, out=19'h0007F, wdata=19'h7FFFF, ack 1st BUSY cycle -> dmem_we=1, wdata=7FFFF,
//    stall exactly 1 cycle, WB_regwrite=0.
//  4 timeout: load, never ack -> req held TIMEOUT cycles, then bus_err=1, WB_rdata=0, state IDLE, stall drops.
//  5 back-to-back load then store -> second req rises the cycle after first ack; addresses/data not mixed.
//  6 rst asserted mid-BUSY -> dmem_req, mem_stall, WB_* to 0 immediately (async); clean ALU op after release.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mem_access_stage_pkg                                           |
// | Purpose : Shared constants and types for the MEM stage of the 19-bit     |
// |           pipelined CPU: datapath widths, timeout default, FSM state     |
// |           encoding and the data-memory request record.                   |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package mem_access_stage_pkg;

    localparam int c_DATA_W  = 19;
    localparam int c_ADDR_W  = 10;
    localparam int c_RD_W    = 3;
    localparam int c_TIMEOUT = 15;

    // Stage FSM encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Data-memory request as held stable on the bus for the whole access
    typedef struct packed {
        logic                we;
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mem_access_stage_if                                            |
// | Purpose : Data-memory req/ack bus between the MEM stage and data memory. |
// | Ports   : master - dmem_req/we/addr/wdata out, dmem_ack/rdata in         |
// |           slave  - mirror of master                                      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface mem_access_stage_if
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage_mem_wb_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mem_wb_reg                                                     |
// | Purpose : MEM/WB pipeline register. Bubble has priority over load and    |
// |           clears every field; with neither asserted the register holds.  |
// | Ports   : clk, rst (async, active-high), load, bubble,                   |
// |           in_* bundle + in_rdata  ->  WB_* outputs                       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mem_wb_reg #(
    parameter int DATA_W = 19,
    parameter int RD_W   = 3
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              load,
    input  wire logic              bubble,
    input  wire logic              in_regwrite,
    input  wire logic              in_memtoreg,
    input  wire logic [DATA_W-1:0] in_out,
    input  wire logic [DATA_W-1:0] in_rdata,
    input  wire logic [RD_W-1:0]   in_rd,
    output logic                   WB_regwrite,
    output logic                   WB_memtoreg,
    output logic [DATA_W-1:0]      WB_out,
    output logic [DATA_W-1:0]      WB_rdata,
    output logic [RD_W-1:0]        WB_rd
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_regwrite <= 1'b0;
            WB_memtoreg <= 1'b0;
            WB_out      <= '0;
            WB_rdata    <= '0;
            WB_rd       <= '0;
        end else if (bubble) begin
            WB_regwrite <= 1'b0;
            WB_memtoreg <= 1'b0;
            WB_out      <= '0;
            WB_rdata    <= '0;
            WB_rd       <= '0;
        end else if (load) begin
            WB_regwrite <= in_regwrite;
            WB_memtoreg <= in_memtoreg;
            WB_out      <= in_out;
            WB_rdata    <= in_rdata;
            WB_rd       <= in_rd;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mem_access_stage                                               |
// | Purpose : Consumer of the EX/MEM register. Runs the data-memory access   |
// |           over a req/ack bus, stalls upstream while it is pending,       |
// |           forces completion with a sticky bus error on timeout, and      |
// |           loads the MEM/WB register.                                     |
// | Ports   : clk, rst (async, active-high)                                  |
// |           MEM_* in  - EX/MEM control/data bundle                         |
// |           dmem      - data-memory bus (master side)                      |
// |           mem_stall - freeze upstream pipeline this cycle                |
// |           bus_err   - sticky access-timeout flag                         |
// |           WB_*  out - MEM/WB register                                    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int ADDR_W  = c_ADDR_W,
    parameter int RD_W    = c_RD_W,
    parameter int TIMEOUT = c_TIMEOUT
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              MEM_regwrite,
    input  wire logic              MEM_memtoreg,
    input  wire logic              MEM_memread,
    input  wire logic              MEM_memwrite,
    input  wire logic [DATA_W-1:0] MEM_out,
    input  wire logic [DATA_W-1:0] MEM_wdata,
    input  wire logic [RD_W-1:0]   MEM_rd,
    mem_access_stage_if.master     dmem,
    output logic                   mem_stall,
    output logic                   bus_err,
    output logic                   WB_regwrite,
    output logic                   WB_memtoreg,
    output logic [DATA_W-1:0]      WB_out,
    output logic [DATA_W-1:0]      WB_rdata,
    output logic [RD_W-1:0]        WB_rd
);

    // Counter is one bit wider than strictly needed so it can never wrap
    localparam int               c_CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_bus_err;

    logic                w_access;
    logic                w_stall;
    logic                w_latch;
    logic                w_set_err;
    logic [DATA_W-1:0]   w_rdata_ld;

    // A load+store combination is handled as a store
    assign w_access = MEM_memread | MEM_memwrite;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_latch     = 1'b0;
        w_set_err   = 1'b0;
        w_rdata_ld  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    w_stall     = 1'b1;
                    w_latch     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (dmem.dmem_ack) begin
                    w_rdata_ld  = r_we ? '0 : dmem.dmem_rdata;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    // Forced completion: behaves like an ack returning zero
                    w_set_err   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_we    <= MEM_memwrite;
                r_addr  <= MEM_out[ADDR_W-1:0];
                r_wdata <= MEM_wdata;
            end
            if (w_set_err) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // The bus is driven only from the latch so it stays stable for the
    // whole request regardless of what EX/MEM presents.
    assign dmem.dmem_req   = (r_state == ST_BUSY);
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;

    // Stall is combinational from the MEM_* bundle; masking with rst keeps it
    // low while reset is held even if EX/MEM still shows an access.
    assign mem_stall = w_stall & ~rst;
    assign bus_err   = r_bus_err;

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_mem_wb_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (~w_stall),
        .bubble      (w_stall),
        .in_regwrite (MEM_regwrite),
        .in_memtoreg (MEM_memtoreg),
        .in_out      (MEM_out),
        .in_rdata    (w_rdata_ld),
        .in_rd       (MEM_rd),
        .WB_regwrite (WB_regwrite),
        .WB_memtoreg (WB_memtoreg),
        .WB_out      (WB_out),
        .WB_rdata    (WB_rdata),
        .WB_rd       (WB_rd)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_mem_access_stage                                            |
// | Purpose : Self-checking bench for mem_access_stage: directed vector      |
// |           table, reset-mid-access sequence, and randomized instructions  |
// |           checked against a transaction-level reference model.          |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int c_TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_regwrite, MEM_memtoreg, MEM_memread, MEM_memwrite;
    logic [18:0] MEM_out, MEM_wdata;
    logic [2:0]  MEM_rd;
    logic        mem_stall, bus_err;
    logic        WB_regwrite, WB_memtoreg;
    logic [18:0] WB_out, WB_rdata;
    logic [2:0]  WB_rd;

    int tests_run = 0;
    int fails     = 0;

    mem_access_stage_if #(.DATA_W(19), .ADDR_W(10)) bus ();

    mem_access_stage #(
        .DATA_W (19), .ADDR_W (10), .RD_W (3), .TIMEOUT (c_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_regwrite (MEM_regwrite),
        .MEM_memtoreg (MEM_memtoreg),
        .MEM_memread  (MEM_memread),
        .MEM_memwrite (MEM_memwrite),
        .MEM_out      (MEM_out),
        .MEM_wdata    (MEM_wdata),
        .MEM_rd       (MEM_rd),
        .dmem         (bus),
        .mem_stall    (mem_stall),
        .bus_err      (bus_err),
        .WB_regwrite  (WB_regwrite),
        .WB_memtoreg  (WB_memtoreg),
        .WB_out       (WB_out),
        .WB_rdata     (WB_rdata),
        .WB_rd        (WB_rd)
    );

    always #5 clk = ~clk;

    // One instruction: inputs, memory behaviour (ack after d request cycles,
    // returning rdata), and expected results.
    typedef struct {
        logic        rw, mtr, mr, mw;
        logic [18:0] out, wdata;
        logic [2:0]  rd;
        int          d;
        logic [18:0] rdata;
        int          exp_stall, exp_req;
        logic [18:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: an access stalls for its issue cycle plus
    // every request cycle that ends without completion; a request is
    // abandoned after c_TO cycles, returning zero and raising the error flag.
    function automatic vec_t model(input vec_t v, input logic err_in);
        vec_t r = v;
        r.exp_err = err_in;
        if (!(v.mr || v.mw)) begin
            r.exp_stall = 0; r.exp_req = 0; r.exp_rdata = '0;
        end else if (v.d < c_TO) begin
            r.exp_stall = 1 + v.d;
            r.exp_req   = v.d + 1;
            r.exp_rdata = v.mw ? 19'h0 : v.rdata;
        end else begin
            r.exp_stall = c_TO;
            r.exp_req   = c_TO;
            r.exp_rdata = '0;
            r.exp_err   = 1'b1;
        end
        return r;
    endfunction

    // Entered and left at 1 time unit after a rising edge; acts as the memory.
    task automatic run_instr(input vec_t v, input string tag);
        int stall_n = 0, req_n = 0, cyc = 0;
        bit done = 0, bubble_bad = 0, field_bad = 0;
        MEM_regwrite = v.rw; MEM_memtoreg = v.mtr;
        MEM_memread  = v.mr; MEM_memwrite = v.mw;
        MEM_out = v.out; MEM_wdata = v.wdata; MEM_rd = v.rd;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = v.rdata;
        while (!done && cyc < 40) begin
            #1;
            if (bus.dmem_req === 1'b1) begin
                if (bus.dmem_addr !== v.out[9:0] || bus.dmem_we !== v.mw ||
                    bus.dmem_wdata !== v.wdata) field_bad = 1;
                bus.dmem_ack = (req_n == v.d);
                req_n++;
            end
            #1;
            if (mem_stall === 1'b1) stall_n++; else done = 1;
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0;
            if (!done && (WB_regwrite !== 1'b0 || WB_memtoreg !== 1'b0 ||
                          WB_out !== '0 || WB_rdata !== '0 || WB_rd !== '0))
                bubble_bad = 1;
            cyc++;
        end
        chk({tag, ".completed"},   done, 1);
        chk({tag, ".stall_cycles"}, stall_n, v.exp_stall);
        chk({tag, ".req_cycles"},  req_n, v.exp_req);
        if (v.mr || v.mw) chk({tag, ".req_fields_bad"}, field_bad, 0);
        if (v.exp_stall > 0) chk({tag, ".bubble_bad"}, bubble_bad, 0);
        chk({tag, ".WB_regwrite"}, WB_regwrite, v.rw);
        chk({tag, ".WB_memtoreg"}, WB_memtoreg, v.mtr);
        chk({tag, ".WB_out"},      WB_out, v.out);
        chk({tag, ".WB_rd"},       WB_rd, v.rd);
        chk({tag, ".WB_rdata"},    WB_rdata, v.exp_rdata);
        chk({tag, ".bus_err"},     bus_err, v.exp_err);
    endtask

    vec_t tbl[9];
    vec_t rv;
    logic err_m;

    initial begin
        //        rw  mtr mr  mw  out        wdata      rd  d    rdata      stl req exp_rdata  err
        tbl[0] = '{1, 0, 0, 0, 19'h1A5A5, 19'h00000, 5, 0,   19'h00000, 0,  0,  19'h00000, 0};
        tbl[1] = '{1, 1, 1, 0, 19'h00123, 19'h00000, 2, 3,   19'h15A5A, 4,  4,  19'h15A5A, 0};
        tbl[2] = '{0, 0, 0, 1, 19'h0007F, 19'h7FFFF, 0, 0,   19'h12345, 1,  1,  19'h00000, 0};
        tbl[3] = '{1, 1, 1, 0, 19'h00200, 19'h00000, 3, 1,   19'h0ABCD, 2,  2,  19'h0ABCD, 0};
        tbl[4] = '{0, 0, 0, 1, 19'h003FF, 19'h11111, 0, 2,   19'h33333, 3,  3,  19'h00000, 0};
        tbl[5] = '{1, 1, 1, 1, 19'h00055, 19'h22222, 4, 0,   19'h44444, 1,  1,  19'h00000, 0};
        tbl[6] = '{1, 0, 0, 0, 19'h7FFFF, 19'h00000, 7, 0,   19'h00000, 0,  0,  19'h00000, 0};
        tbl[7] = '{1, 1, 1, 0, 19'h000AA, 19'h00000, 6, 100, 19'h55555, 15, 15, 19'h00000, 1};
        tbl[8] = '{1, 0, 0, 0, 19'h01234, 19'h00000, 1, 0,   19'h00000, 0,  0,  19'h00000, 1};

        rst = 1'b1;
        MEM_regwrite = 0; MEM_memtoreg = 0; MEM_memread = 0; MEM_memwrite = 0;
        MEM_out = '0; MEM_wdata = '0; MEM_rd = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.dmem_req",    bus.dmem_req, 0);
        chk("reset.mem_stall",   mem_stall, 0);
        chk("reset.bus_err",     bus_err, 0);
        chk("reset.WB_regwrite", WB_regwrite, 0);
        chk("reset.WB_out",      WB_out, 0);
        chk("reset.WB_rdata",    WB_rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a pending load
        MEM_regwrite = 1; MEM_memtoreg = 1; MEM_memread = 1; MEM_memwrite = 0;
        MEM_out = 19'h001F0; MEM_rd = 3'd2; bus.dmem_ack = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("midrst.req_before", bus.dmem_req, 1);
        #3 rst = 1'b1;
        #1;
        chk("midrst.dmem_req",    bus.dmem_req, 0);
        chk("midrst.mem_stall",   mem_stall, 0);
        chk("midrst.bus_err",     bus_err, 0);
        chk("midrst.WB_regwrite", WB_regwrite, 0);
        chk("midrst.WB_out",      WB_out, 0);
        MEM_regwrite = 0; MEM_memtoreg = 0; MEM_memread = 0;
        MEM_out = '0; MEM_rd = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(tbl[0], "post_rst_alu");

        // Randomized instructions against the reference model
        err_m = 1'b0;
        for (int n = 0; n < 60; n++) begin
            rv = tbl[0];
            rv.rw    = 1'($urandom);
            rv.mtr   = 1'($urandom);
            rv.mr    = ($urandom_range(0, 2) == 0);
            rv.mw    = ($urandom_range(0, 2) == 0);
            rv.out   = 19'($urandom);
            rv.wdata = 19'($urandom);
            rv.rd    = 3'($urandom);
            rv.rdata = 19'($urandom);
            rv.d     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 17))
                                                    : int'($urandom_range(0, 3));
            rv = model(rv, err_m);
            err_m = rv.exp_err;
            run_instr(rv, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
